// File: rtl/tdc_histogrammer.sv
// tdc_histogrammer: sorts TDC events into two interval histograms plus coincidence/drop counters, host read port
module tdc_histogrammer #(
  parameter int NBINS = 128,
  parameter int CNT_W = 16,
  localparam int AW = $clog2(NBINS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       START_signal,
  input  logic [1:0]       END_signal,
  input  logic [AW-1:0]    INTERVAL,
  input  logic             data_arrived,
  input  logic             clear,
  input  logic             rd_req,
  input  logic [1:0]       rd_sel,
  input  logic [AW-1:0]    rd_addr,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_data,
  output logic             busy
);
  typedef enum logic [1:0] {SWEEP, IDLE, UPDATE, READ} state_t;
  state_t state_q, state_d;
  logic da_q, da_d, busy_q, busy_d, rd_valid_q, rd_valid_d;
  logic q_vld_q, q_vld_d, q_sel_q, q_sel_d, upd_sel_q, upd_sel_d, pend_q, pend_d;
  logic [1:0] ph_q, ph_d, pend_sel_q, pend_sel_d, rsel_q, rsel_d;
  logic [AW-1:0] sweep_addr_q, sweep_addr_d, upd_bin_q, upd_bin_d, q_bin_q, q_bin_d, pend_addr_q, pend_addr_d;
  logic [CNT_W-1:0] coinc_q, coinc_d, dropped_q, dropped_d, rd_data_q, rd_data_d;
  logic [CNT_W-1:0] ram_a [NBINS];
  logic [CNT_W-1:0] ram_b [NBINS];
  logic [CNT_W-1:0] a_rd_q, b_rd_q, wd;
  logic [AW-1:0] ra, wa;
  logic strobe, is_a, is_b, hist, coin, sweep, wr;

  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] x);
    return &x ? x : x + 1'b1;
  endfunction

  // event decode and RAM port steering: the sweep owns the write port, an update writes in its last phase
  always_comb begin
    strobe = data_arrived & ~da_q;
    is_a = START_signal == 2'b10 && END_signal == 2'b01;
    is_b = START_signal == 2'b01 && END_signal == 2'b10;
    hist = strobe && (is_a || is_b);
    coin = strobe && END_signal == 2'b11;
    sweep = state_q == SWEEP;
    wr = sweep || (state_q == UPDATE && ph_q == 2'd2);
    wa = sweep ? sweep_addr_q : upd_bin_q;
    wd = sweep ? '0 : sat(upd_sel_q ? b_rd_q : a_rd_q);
    ra = state_q == IDLE ? (pend_q ? pend_addr_q : rd_addr) : upd_bin_q;
  end

  // next-state: sweep, idle dispatch (update before read), 3-phase RMW, single-cycle read completion
  always_comb begin
    state_d = state_q;
    da_d = data_arrived;
    sweep_addr_d = sweep_addr_q;
    ph_d = ph_q;
    upd_sel_d = upd_sel_q;
    upd_bin_d = upd_bin_q;
    q_vld_d = q_vld_q;
    q_sel_d = q_sel_q;
    q_bin_d = q_bin_q;
    pend_d = pend_q;
    pend_sel_d = pend_sel_q;
    pend_addr_d = pend_addr_q;
    rsel_d = rsel_q;
    coinc_d = coinc_q;
    dropped_d = dropped_q;
    rd_valid_d = 1'b0;
    rd_data_d = rd_data_q;
    if (sweep) begin
      if (strobe) dropped_d = sat(dropped_q);
      sweep_addr_d = sweep_addr_q + 1'b1;
      if (sweep_addr_q == AW'(NBINS - 1)) state_d = IDLE;
    end else begin
      if (coin) coinc_d = sat(coinc_q);
      if (state_q == IDLE) begin
        if (q_vld_q || hist) begin
          state_d = UPDATE;
          ph_d = 2'd0;
          upd_sel_d = q_vld_q ? q_sel_q : is_b;
          upd_bin_d = q_vld_q ? q_bin_q : INTERVAL;
          q_vld_d = q_vld_q && hist;
          q_sel_d = is_b;
          q_bin_d = INTERVAL;
          if (rd_req && !pend_q) begin
            pend_d = 1'b1;
            pend_sel_d = rd_sel;
            pend_addr_d = rd_addr;
          end
        end else if (pend_q || rd_req) begin
          state_d = READ;
          rsel_d = pend_q ? pend_sel_q : rd_sel;
          pend_d = 1'b0;
        end
      end else begin
        if (hist && q_vld_q) dropped_d = sat(dropped_q);
        else if (hist) begin
          q_vld_d = 1'b1;
          q_sel_d = is_b;
          q_bin_d = INTERVAL;
        end
        if (rd_req && !pend_q) begin
          pend_d = 1'b1;
          pend_sel_d = rd_sel;
          pend_addr_d = rd_addr;
        end
        if (state_q == UPDATE) begin
          ph_d = ph_q + 1'b1;
          if (ph_q == 2'd2) state_d = IDLE;
        end else begin
          state_d = IDLE;
          rd_valid_d = 1'b1;
          rd_data_d = rsel_q[1] ? (rsel_q[0] ? dropped_q : coinc_q) : (rsel_q[0] ? b_rd_q : a_rd_q);
        end
      end
    end
    if (clear) begin
      state_d = SWEEP;
      sweep_addr_d = '0;
      coinc_d = '0;
      dropped_d = '0;
      q_vld_d = 1'b0;
      pend_d = 1'b0;
      rd_valid_d = 1'b0;
    end
    busy_d = state_d == SWEEP;
  end

  // control and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SWEEP;
      da_q <= 1'b0;
      busy_q <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_data_q <= '0;
      sweep_addr_q <= '0;
      ph_q <= '0;
      upd_sel_q <= 1'b0;
      upd_bin_q <= '0;
      q_vld_q <= 1'b0;
      q_sel_q <= 1'b0;
      q_bin_q <= '0;
      pend_q <= 1'b0;
      pend_sel_q <= '0;
      pend_addr_q <= '0;
      rsel_q <= '0;
      coinc_q <= '0;
      dropped_q <= '0;
    end else begin
      state_q <= state_d;
      da_q <= da_d;
      busy_q <= busy_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q <= rd_data_d;
      sweep_addr_q <= sweep_addr_d;
      ph_q <= ph_d;
      upd_sel_q <= upd_sel_d;
      upd_bin_q <= upd_bin_d;
      q_vld_q <= q_vld_d;
      q_sel_q <= q_sel_d;
      q_bin_q <= q_bin_d;
      pend_q <= pend_d;
      pend_sel_q <= pend_sel_d;
      pend_addr_q <= pend_addr_d;
      rsel_q <= rsel_d;
      coinc_q <= coinc_d;
      dropped_q <= dropped_d;
    end
  end

  // histogram RAMs: no reset, contents zeroed by the sweep; registered read every cycle
  always_ff @(posedge clk) begin
    if (wr && (sweep || !upd_sel_q)) ram_a[wa] <= wd;
    if (wr && (sweep || upd_sel_q)) ram_b[wa] <= wd;
    a_rd_q <= ram_a[ra];
    b_rd_q <= ram_b[ra];
  end

  assign rd_valid = rd_valid_q;
  assign rd_data = rd_data_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_tdc_histogrammer.sv
// tb_tdc_histogrammer: randomized bench for tdc_histogrammer against an array-based histogram model
module tb_tdc_histogrammer;
  localparam int CW = 4;
  localparam int NB = 128;
  localparam int MAXV = (1 << CW) - 1;

  logic clk = 0, rst = 1;
  logic [1:0] START_signal = 0, END_signal = 0, rd_sel = 0;
  logic [6:0] INTERVAL = 0, rd_addr = 0;
  logic data_arrived = 0, clear = 0, rd_req = 0;
  logic rd_valid, busy;
  logic [CW-1:0] rd_data;

  int vectors = 0, miscompares = 0;
  int ha[NB], hb[NB], mc = 0, md = 0;

  tdc_histogrammer #(.NBINS(NB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .START_signal(START_signal), .END_signal(END_signal),
    .INTERVAL(INTERVAL), .data_arrived(data_arrived), .clear(clear), .rd_req(rd_req),
    .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int inc(int x);
    return x < MAXV ? x + 1 : x;
  endfunction

  function automatic int model_val(int sel, int a);
    return sel == 0 ? ha[a] : sel == 1 ? hb[a] : sel == 2 ? mc : md;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_zero;
    for (int i = 0; i < NB; i++) begin
      ha[i] = 0;
      hb[i] = 0;
    end
    mc = 0;
    md = 0;
  endtask

  task automatic model_event(input logic [1:0] s, input logic [1:0] e, input int i);
    if (e == 2'b11) mc = inc(mc);
    else if (s == 2'b10 && e == 2'b01) ha[i] = inc(ha[i]);
    else if (s == 2'b01 && e == 2'b10) hb[i] = inc(hb[i]);
  endtask

  task automatic send_event(input logic [1:0] s, input logic [1:0] e, input logic [6:0] i);
    START_signal = s;
    END_signal = e;
    INTERVAL = i;
    data_arrived = 1;
    tick;
    tick;
    data_arrived = 0;
    tick;
    tick;
    model_event(s, e, int'(i));
  endtask

  task automatic do_read(input logic [1:0] sel, input logic [6:0] a, output logic [CW-1:0] d, output int lat);
    rd_req = 1;
    rd_sel = sel;
    rd_addr = a;
    tick;
    rd_req = 0;
    lat = 1;
    while (!rd_valid && lat < 20) begin
      tick;
      lat++;
    end
    d = rd_data;
  endtask

  task automatic do_clear(output int n);
    clear = 1;
    tick;
    clear = 0;
    n = 0;
    while (busy && n < 300) begin
      n++;
      tick;
    end
    model_zero;
  endtask

  task automatic test_reset;
    logic [CW-1:0] d;
    int lat, n;
    model_zero;
    rst = 1;
    tick;
    tick;
    vectors++;
    if (busy !== 1'b1 || rd_valid !== 1'b0 || rd_data !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b rd_valid=%b rd_data=%0d, want 1 0 0", busy, rd_valid, rd_data);
    end
    rst = 0;
    n = 0;
    while (busy && n < 300) begin
      n++;
      tick;
    end
    vectors++;
    if (n != NB) begin
      miscompares++;
      $display("FAIL reset_busy_len: %0d cycles, want %0d", n, NB);
    end
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 3; k++) begin
        do_read(2'(s), 7'(k * 63 + (k == 2 ? 1 : 0)), d, lat);
        vectors++;
        if (d !== '0 || lat != 2) begin
          miscompares++;
          $display("FAIL reset_read sel%0d: data %0d lat %0d, want 0 lat 2", s, d, lat);
        end
      end
  endtask

  task automatic test_hist_basic;
    logic [CW-1:0] d;
    int lat;
    repeat (3) send_event(2'b10, 2'b01, 7'd5);
    do_read(2'd0, 7'd5, d, lat);
    vectors++;
    if (d !== CW'(ha[5]) || ha[5] != 3 || lat != 2) begin
      miscompares++;
      $display("FAIL hist_a5: data %0d lat %0d, want 3 lat 2", d, lat);
    end
    do_read(2'd1, 7'd5, d, lat);
    vectors++;
    if (d !== CW'(hb[5]) || lat != 2) begin
      miscompares++;
      $display("FAIL hist_b5: data %0d lat %0d, want %0d lat 2", d, lat, hb[5]);
    end
  endtask

  task automatic test_coinc_discard;
    logic [CW-1:0] d;
    int lat;
    send_event(2'b00, 2'b11, 7'd9);
    send_event(2'b11, 2'b01, 7'd5);
    for (int s = 0; s < 4; s++) begin
      do_read(2'(s), 7'd5, d, lat);
      vectors++;
      if (d !== CW'(model_val(s, 5)) || lat != 2) begin
        miscompares++;
        $display("FAIL coinc_discard sel%0d: data %0d lat %0d, want %0d lat 2", s, d, lat, model_val(s, 5));
      end
    end
  endtask

  task automatic test_saturation;
    logic [CW-1:0] d;
    int lat;
    repeat (MAXV + 1) send_event(2'b01, 2'b10, 7'd127);
    do_read(2'd1, 7'd127, d, lat);
    vectors++;
    if (d !== CW'(MAXV) || lat != 2) begin
      miscompares++;
      $display("FAIL sat_b127: data %0d lat %0d, want %0d lat 2", d, lat, MAXV);
    end
    do_read(2'd0, 7'd127, d, lat);
    vectors++;
    if (d !== CW'(ha[127])) begin
      miscompares++;
      $display("FAIL sat_a127: data %0d, want %0d", d, ha[127]);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    START_signal = 2'b10;
    END_signal = 2'b01;
    INTERVAL = 7'd9;
    data_arrived = 1;
    rd_req = 1;
    rd_sel = 2'd0;
    rd_addr = 7'd9;
    model_event(2'b10, 2'b01, 9);
    tick;
    rd_req = 0;
    lat = 1;
    while (!rd_valid && lat < 20) begin
      if (lat == 2) data_arrived = 0;
      tick;
      lat++;
    end
    data_arrived = 0;
    vectors++;
    if (rd_data !== CW'(ha[9]) || lat != 6) begin
      miscompares++;
      $display("FAIL back_to_back: data %0d lat %0d, want %0d lat 6", rd_data, lat, ha[9]);
    end
    repeat (3) tick;
  endtask

  // strobes every 2 cycles: first runs, second waits in the 1-deep queue,
  // third refills the queue as it drains, fourth finds it full and is dropped
  task automatic test_queue_drop;
    logic [CW-1:0] d;
    int lat;
    for (int k = 0; k < 4; k++) begin
      START_signal = 2'b10;
      END_signal = 2'b01;
      INTERVAL = 7'(30 + k);
      data_arrived = 1;
      tick;
      data_arrived = 0;
      tick;
      if (k < 3) ha[30 + k] = inc(ha[30 + k]);
    end
    md = inc(md);
    repeat (8) tick;
    for (int k = 0; k < 4; k++) begin
      do_read(2'd0, 7'(30 + k), d, lat);
      vectors++;
      if (d !== CW'(ha[30 + k]) || lat != 2) begin
        miscompares++;
        $display("FAIL queue_bin%0d: data %0d lat %0d, want %0d lat 2", 30 + k, d, lat, ha[30 + k]);
      end
    end
    do_read(2'd3, 7'd0, d, lat);
    vectors++;
    if (d !== CW'(md)) begin
      miscompares++;
      $display("FAIL queue_dropped: data %0d, want %0d", d, md);
    end
  endtask

  task automatic test_clear_mid_update;
    logic [CW-1:0] d;
    int lat, n, a;
    START_signal = 2'b10;
    END_signal = 2'b01;
    INTERVAL = 7'd20;
    data_arrived = 1;
    tick;
    clear = 1;
    tick;
    clear = 0;
    n = 0;
    while (busy && n < 300) begin
      n++;
      if (n == 2) data_arrived = 0;
      if (n == 4) begin
        START_signal = 2'b01;
        END_signal = 2'b10;
        data_arrived = 1;
      end
      if (n == 6) data_arrived = 0;
      tick;
    end
    model_zero;
    md = 1;
    vectors++;
    if (n != NB) begin
      miscompares++;
      $display("FAIL clear_busy_len: %0d cycles, want %0d", n, NB);
    end
    for (int k = 0; k < 8; k++) begin
      a = k < 2 ? 20 : k < 4 ? 127 : int'($urandom_range(0, NB - 1));
      do_read(2'(k % 2), 7'(a), d, lat);
      vectors++;
      if (d !== '0 || lat != 2) begin
        miscompares++;
        $display("FAIL clear_bin sel%0d addr%0d: data %0d lat %0d, want 0 lat 2", k % 2, a, d, lat);
      end
    end
    for (int s = 2; s < 4; s++) begin
      do_read(2'(s), 7'd0, d, lat);
      vectors++;
      if (d !== CW'(model_val(s, 0))) begin
        miscompares++;
        $display("FAIL clear_counter sel%0d: data %0d, want %0d", s, d, model_val(s, 0));
      end
    end
  endtask

  task automatic test_random;
    logic [CW-1:0] d;
    logic [1:0] s, e;
    int lat, n, r, a;
    do_clear(n);
    vectors++;
    if (n != NB) begin
      miscompares++;
      $display("FAIL random_clear_len: %0d cycles, want %0d", n, NB);
    end
    repeat (60) begin
      r = int'($urandom_range(0, 9));
      s = r < 4 ? 2'b10 : r < 7 ? 2'b01 : 2'($urandom);
      e = r < 4 ? 2'b01 : r < 7 ? 2'b10 : r == 7 ? 2'b11 : 2'($urandom);
      a = $urandom_range(0, 7) == 0 ? 127 : int'($urandom_range(0, 7));
      send_event(s, e, 7'(a));
    end
    for (int k = 0; k < 20; k++) begin
      a = k < 18 ? (k % 9 == 8 ? 127 : k % 9) : 0;
      r = k < 18 ? k / 9 : k - 16;
      do_read(2'(r), 7'(a), d, lat);
      vectors++;
      if (d !== CW'(model_val(r, a)) || lat != 2) begin
        miscompares++;
        $display("FAIL random_read sel%0d addr%0d: data %0d lat %0d, want %0d lat 2", r, a, d, lat, model_val(r, a));
      end
    end
  endtask

  initial begin
    test_reset;
    test_hist_basic;
    test_coinc_discard;
    test_saturation;
    test_back_to_back;
    test_queue_drop;
    test_clear_mid_update;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
